// File: rtl/mult_share_if.sv
// Requester-side handshake bundle for the shared multiplier controller.
// Ports (modports):
//   master : requester side  - drives req_valid/req_a/req_b/rsp_ready
//   slave  : controller side - drives req_ready/rsp_valid/rsp_data
// Operand packing: requester i owns bits [i*W +: W] of req_a/req_b.
interface mult_share_if #(
   parameter int NREQ = 3,
   parameter int W    = 5
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [2*W-1:0]    rsp_data;
   logic [NREQ-1:0]   rsp_ready;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mult_share_ctrl.sv
// Shares one combinational WxW multiplier among NREQ requesters.
// A round-robin arbiter accepts one operand pair, launches it on registered
// mul_in1/mul_in2, waits SETTLE cycles for the array to settle, captures
// mul_out and returns it to the owner with a held one-hot rsp_valid.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   bus (slave)        request/response handshakes (see mult_share_if)
//   mul_in1, mul_in2   registered operands to the multiplier
//   mul_out            2W-bit product from the multiplier
//   busy               high whenever an operation is in flight
//   grant_id           index of the current or most recent owner
module mult_share_ctrl #(
   parameter int NREQ   = 3,
   parameter int W      = 5,
   parameter int SETTLE = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_share_if.slave    bus,
   output logic [W-1:0]   mul_in1,
   output logic [W-1:0]   mul_in2,
   input  logic [2*W-1:0] mul_out,
   output logic           busy,
   output logic [2:0]     grant_id
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [2:0]    last_grant;
   logic [2:0]    win;
   logic          found;
   logic [3:0]    idx;
   logic [CW-1:0] cnt;

   // Round-robin search starting just after the last owner; the first
   // requester found in rotation order wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = {1'b0, last_grant} + 4'(k);
         if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
         if (!found && bus.req_valid[idx[IW-1:0]]) begin
            found = 1'b1;
            win   = idx[2:0];
         end
      end
   end

   // Accept strobe is combinational and only offered in IDLE; gated by
   // rst_n so nothing looks accepted while reset is held.
   assign bus.req_ready = (rst_n && state == IDLE && found) ? (NREQ'(1) << win) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant    <= 3'(NREQ-1);
         grant_id      <= '0;
         mul_in1       <= '0;
         mul_in2       <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_valid <= '0;
         busy          <= 1'b0;
         cnt           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  mul_in1    <= bus.req_a[win*W +: W];
                  mul_in2    <= bus.req_b[win*W +: W];
                  grant_id   <= win;
                  last_grant <= win;
                  cnt        <= CW'(SETTLE-1);
                  busy       <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  bus.rsp_data  <= mul_out;
                  bus.rsp_valid <= NREQ'(1) << grant_id;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               // rsp_valid is one-hot on the owner, so masking with it
               // ignores rsp_ready from everyone else.
               if (|(bus.rsp_ready & bus.rsp_valid)) begin
                  bus.rsp_valid <= '0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
